// File: rtl/sal_ref_sched.sv
// sal_ref_sched: refresh scheduler for the DDR2 controller.
//
// Sits between the per-bank controllers and the command scheduler. A free
// running interval counter produces one refresh "tick" every TREFI cycles.
// Each tick adds one owed refresh, saturating at MAX_OWED. The FSM retires
// owed refreshes in one of two ways:
//   - opportunistically, whenever every bank is already idle;
//   - forcibly, by draining the banks once URGENT_TH refreshes are owed.
// It then holds an all-bank REFRESH request until it is granted, and keeps
// the banks locked out for TRFC cycles after each grant.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   bk_idle_arr  per-bank "precharged and nothing in flight" flags
//   drain_req    banks must stop ACT and precharge their open rows
//   ref_req      request for an all-bank REFRESH command slot
//   ref_gnt      command scheduler issued the REFRESH this cycle
//   ref_busy     tRFC lockout active; no ACT may be issued
//   owed_cnt     current number of owed refreshes
//   owed_ovf     sticky: a tick arrived while owed_cnt was at MAX_OWED

module sal_ref_sched #(
  parameter int BK_CNT    = 8,
  parameter int TREFI     = 780,
  parameter int TRFC      = 13,
  parameter int MAX_OWED  = 8,
  parameter int URGENT_TH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BK_CNT-1:0] bk_idle_arr,
  output logic              drain_req,
  output logic              ref_req,
  input  logic              ref_gnt,
  output logic              ref_busy,
  output logic [3:0]        owed_cnt,
  output logic              owed_ovf
);

  // The lockout counter only has to hold TRFC-1.
  localparam int RFC_W = (TRFC > 1) ? $clog2(TRFC) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, TRFC_WAIT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_intCnt;
  logic [RFC_W-1:0] r_rfcCnt;
  logic [3:0]       r_owedCnt;
  logic             r_owedOvf;
  logic             r_drainReq;
  logic             r_refReq;
  logic             r_refBusy;

  logic             w_tick;
  logic             w_allIdle;
  logic             w_gnt;
  logic             w_urgent;
  logic             w_owedSat;
  logic [3:0]       w_owedNext;

  assign w_tick    = (r_intCnt == CNT_W'(TREFI - 1));
  assign w_allIdle = &bk_idle_arr;
  assign w_urgent  = (r_owedCnt >= 4'(URGENT_TH));
  assign w_owedSat = (r_owedCnt == 4'(MAX_OWED));
  // A grant only counts while we are actually asking for a slot.
  assign w_gnt     = ref_gnt && (r_state == REQ);

  // Interval counter: free-runs 0..TREFI-1 and wraps on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_intCnt <= '0;
    end else if (w_tick) begin
      r_intCnt <= '0;
    end else begin
      r_intCnt <= r_intCnt + 1'b1;
    end
  end

  // Owed-count update. A tick and a grant in the same cycle cancel out;
  // otherwise a tick adds one (saturating) and a grant retires one (never
  // below zero).
  always_comb begin
    w_owedNext = r_owedCnt;
    if (w_tick && !w_gnt) begin
      if (!w_owedSat) begin
        w_owedNext = r_owedCnt + 4'd1;
      end
    end else if (w_gnt && !w_tick) begin
      if (r_owedCnt != 4'd0) begin
        w_owedNext = r_owedCnt - 4'd1;
      end
    end
  end

  // Owed counter and the sticky overflow flag; the flag marks a refresh
  // that was lost because the postponement credit was already used up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owedCnt <= 4'd0;
      r_owedOvf <= 1'b0;
    end else begin
      r_owedCnt <= w_owedNext;
      if (w_tick && w_owedSat) begin
        r_owedOvf <= 1'b1;
      end
    end
  end

  // Refresh sequencing FSM. Outputs are registered together with the state
  // they belong to, so each output is a clean function of the state register.
  // drain_req stays high from DRAIN through the lockout so banks cannot
  // reopen rows between back-to-back refreshes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rfcCnt   <= '0;
      r_drainReq <= 1'b0;
      r_refReq   <= 1'b0;
      r_refBusy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((r_owedCnt != 4'd0) && w_allIdle) begin
            r_state    <= REQ;
            r_drainReq <= 1'b1;
            r_refReq   <= 1'b1;
          end else if (w_urgent) begin
            r_state    <= DRAIN;
            r_drainReq <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_allIdle) begin
            r_state  <= REQ;
            r_refReq <= 1'b1;
          end
        end
        REQ: begin
          if (ref_gnt) begin
            r_state   <= TRFC_WAIT;
            r_refReq  <= 1'b0;
            r_refBusy <= 1'b1;
            r_rfcCnt  <= RFC_W'(TRFC - 1);
          end
        end
        TRFC_WAIT: begin
          if (r_rfcCnt == '0) begin
            r_refBusy <= 1'b0;
            if (w_urgent) begin
              // Banks are still idle, so go straight back to requesting.
              r_state  <= REQ;
              r_refReq <= 1'b1;
            end else begin
              r_state    <= IDLE;
              r_drainReq <= 1'b0;
            end
          end else begin
            r_rfcCnt <= r_rfcCnt - 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_drainReq <= 1'b0;
          r_refReq   <= 1'b0;
          r_refBusy  <= 1'b0;
        end
      endcase
    end
  end

  assign drain_req = r_drainReq;
  assign ref_req   = r_refReq;
  assign ref_busy  = r_refBusy;
  assign owed_cnt  = r_owedCnt;
  assign owed_ovf  = r_owedOvf;

endmodule

// File: tb/tb_sal_ref_sched.sv
// tb_sal_ref_sched: directed testbench for the refresh scheduler.
// Inputs change 1 time unit after a rising edge and outputs are sampled
// there as well, well away from the next active edge.

module tb_sal_ref_sched;

  localparam int TREFI = 780;
  localparam int TRFC  = 13;

  logic       clk;
  logic       rst;
  logic [7:0] bk_idle_arr;
  logic       drain_req;
  logic       ref_req;
  logic       ref_gnt;
  logic       ref_busy;
  logic [3:0] owed_cnt;
  logic       owed_ovf;

  int checks;
  int failures;
  int cyc;
  int tMark;

  sal_ref_sched dut (
    .clk         (clk),
    .rst         (rst),
    .bk_idle_arr (bk_idle_arr),
    .drain_req   (drain_req),
    .ref_req     (ref_req),
    .ref_gnt     (ref_gnt),
    .ref_busy    (ref_busy),
    .owed_cnt    (owed_cnt),
    .owed_ovf    (owed_ovf)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference cycle count since reset; equals the DUT interval counter
  // value modulo TREFI, so a multiple of TREFI marks the edge where a tick
  // has just been applied to owed_cnt.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic applyStimulus(input logic rstV, input logic [7:0] idleV, input logic gntV);
    rst         = rstV;
    bk_idle_arr = idleV;
    ref_gnt     = gntV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Step until the next tick edge, bounded to a little more than one interval.
  task automatic advanceToTick();
    for (int i = 0; i < TREFI + 20; i++) begin
      waitEdges(1);
      if (cyc % TREFI == 0) break;
    end
  endtask

  // Wait (bounded) for ref_req, grant for exactly one cycle, and return one
  // time unit after the grant edge.
  task automatic serviceRefresh(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (ref_req === 1'b1) break;
      waitEdges(1);
    end
    checkOutput(tag, ref_req, 1);
    ref_gnt = 1'b1;
    waitEdges(1);
    ref_gnt = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    tMark    = 0;

    // Reset state.
    applyStimulus(1'b1, 8'h00, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst_drain", drain_req, 0);
    checkOutput("rst_req",   ref_req,   0);
    checkOutput("rst_busy",  ref_busy,  0);
    checkOutput("rst_owed",  owed_cnt,  0);
    checkOutput("rst_ovf",   owed_ovf,  0);

    // Banks busy: owed_cnt steps exactly at each interval boundary.
    for (int k = 1; k <= 4; k++) begin
      waitEdges(TREFI - 1);
      checkOutput("pre_tick_owed", owed_cnt, 32'(k - 1));
      waitEdges(1);
      checkOutput("post_tick_owed", owed_cnt, 32'(k));
      checkOutput("busy_banks_req", ref_req, 0);
    end
    checkOutput("drain_not_yet", drain_req, 0);
    waitEdges(1);
    checkOutput("drain_urgent", drain_req, 1);
    checkOutput("drain_no_req", ref_req,   0);

    // Banks become idle: request next cycle, grant it, 13-cycle lockout.
    bk_idle_arr = 8'hFF;
    waitEdges(1);
    checkOutput("req_after_idle", ref_req, 1);
    checkOutput("req_drain",      drain_req, 1);
    ref_gnt = 1'b1;
    waitEdges(1);
    ref_gnt = 1'b0;
    checkOutput("gnt_owed",   owed_cnt, 3);
    checkOutput("gnt_req_lo", ref_req,  0);
    checkOutput("busy_c1",    ref_busy, 1);
    for (int i = 2; i <= TRFC; i++) begin
      waitEdges(1);
      checkOutput("busy_hold", ref_busy, 1);
    end
    waitEdges(1);
    checkOutput("busy_end",       ref_busy,  0);
    checkOutput("idle_drain_lo",  drain_req, 0);
    checkOutput("idle_req_lo",    ref_req,   0);
    waitEdges(1);
    checkOutput("opportunistic_req", ref_req, 1);

    // Retire the remaining owed refreshes.
    serviceRefresh("drain_a");
    serviceRefresh("drain_b");
    serviceRefresh("drain_c");
    checkOutput("drained_owed", owed_cnt, 0);
    waitEdges(TRFC);
    checkOutput("drained_idle_drain", drain_req, 0);
    checkOutput("drained_idle_busy",  ref_busy,  0);

    // Banks always idle: one refresh per interval, owed_cnt toggles 0/1.
    for (int k = 0; k < 2; k++) begin
      advanceToTick();
      checkOutput("steady_owed1",  owed_cnt,  1);
      checkOutput("steady_drain0", drain_req, 0);
      if (k == 1) checkOutput("steady_period", 32'(cyc - tMark), 32'(TREFI));
      tMark = cyc;
      waitEdges(1);
      checkOutput("steady_req",   ref_req,   1);
      checkOutput("steady_drain", drain_req, 1);
      serviceRefresh("steady_gnt");
      checkOutput("steady_owed0", owed_cnt, 0);
      waitEdges(TRFC);
      checkOutput("steady_back_idle", drain_req, 0);
      checkOutput("steady_no_req",    ref_req,   0);
    end

    // Banks never idle, no grants: saturation and sticky overflow.
    bk_idle_arr = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      advanceToTick();
      checkOutput("sat_owed", owed_cnt, 32'(k));
      checkOutput("sat_ovf0", owed_ovf, 0);
    end
    advanceToTick();
    checkOutput("sat_owed_max", owed_cnt, 8);
    checkOutput("sat_ovf1",     owed_ovf, 1);
    checkOutput("sat_drain",    drain_req, 1);
    checkOutput("sat_no_req",   ref_req,   0);

    // Release the banks: back-to-back refreshes while owed stays urgent.
    bk_idle_arr = 8'hFF;
    serviceRefresh("b2b_first");
    checkOutput("b2b_owed7", owed_cnt, 7);
    waitEdges(TRFC - 1);
    checkOutput("b2b_busy_last", ref_busy, 1);
    checkOutput("b2b_req_lo",    ref_req,  0);
    waitEdges(1);
    checkOutput("b2b_req_hi",   ref_req,  1);
    checkOutput("b2b_busy_lo",  ref_busy, 0);
    for (int k = 0; k < 7; k++) begin
      serviceRefresh("b2b_rest");
    end
    checkOutput("b2b_owed0",  owed_cnt, 0);
    checkOutput("ovf_sticky", owed_ovf, 1);

    // Tick coinciding with a grant leaves owed_cnt unchanged.
    bk_idle_arr = 8'h00;
    advanceToTick();
    advanceToTick();
    checkOutput("coin_setup_owed", owed_cnt, 2);
    bk_idle_arr = 8'hFF;
    waitEdges(1);
    checkOutput("coin_req", ref_req, 1);
    for (int i = 0; i < TREFI + 20; i++) begin
      if (cyc % TREFI == TREFI - 1) break;
      waitEdges(1);
    end
    ref_gnt = 1'b1;
    waitEdges(1);
    ref_gnt = 1'b0;
    bk_idle_arr = 8'h00;
    checkOutput("coin_owed", owed_cnt, 2);
    checkOutput("coin_busy", ref_busy, 1);
    waitEdges(TRFC);
    checkOutput("coin_idle_busy", ref_busy, 0);
    checkOutput("coin_idle_req",  ref_req,  0);

    // Spurious grant in IDLE has no effect.
    ref_gnt = 1'b1;
    waitEdges(1);
    ref_gnt = 1'b0;
    checkOutput("spur_owed", owed_cnt, 2);
    checkOutput("spur_busy", ref_busy, 0);
    checkOutput("spur_req",  ref_req,  0);
    waitEdges(1);
    checkOutput("spur_owed_later", owed_cnt, 2);

    // Reset in lockout cycle 5 aborts the refresh and restarts the interval.
    bk_idle_arr = 8'hFF;
    serviceRefresh("rstmid_gnt");
    waitEdges(4);
    checkOutput("rstmid_busy_c5", ref_busy, 1);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 8'hFF, 1'b0);
    checkOutput("rstmid_drain", drain_req, 0);
    checkOutput("rstmid_req",   ref_req,   0);
    checkOutput("rstmid_busy",  ref_busy,  0);
    checkOutput("rstmid_owed",  owed_cnt,  0);
    checkOutput("rstmid_ovf",   owed_ovf,  0);
    waitEdges(TREFI - 1);
    checkOutput("restart_pre_tick", owed_cnt, 0);
    waitEdges(1);
    checkOutput("restart_tick", owed_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
